// File: rtl/onehot_pkg.sv
// Shared command encodings for the one-hot select sequencer.
package onehot_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD   = 2'b00,
    MODE_LOAD   = 2'b01,
    MODE_ROT_UP = 2'b10,
    MODE_ROT_DN = 2'b11
  } mode_e;

  function automatic logic is_rotate(input mode_e m);
    return (m == MODE_ROT_UP) || (m == MODE_ROT_DN);
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational index-to-one-hot decoder.
module onehot_dec #(
  parameter int N = 4
) (
  input  logic [N-1:0]    idx,
  output logic [2**N-1:0] onehot
);

  // Single bit set at position idx.
  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/onehot_select_seq.sv
// Registered one-hot select with load, prescaled up/down rotation and wrap pulse.
module onehot_select_seq
  import onehot_pkg::*;
#(
  parameter int N        = 4,
  parameter int STEP_DIV = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic [MODE_W-1:0]   mode,
  input  logic [N-1:0]        idx,
  output logic [2**N-1:0]     Tsig,
  output logic [N-1:0]        cur_idx,
  output logic                active,
  output logic                wrap
);

  localparam int W  = 2**N;
  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);
  localparam logic [PW-1:0] PRESC_ZERO = '0;
  localparam logic [N-1:0]  IDX_MAX    = {N{1'b1}};
  localparam logic [N-1:0]  IDX_ZERO   = '0;

  logic [N-1:0]  cur_q,   cur_d;
  logic          act_q,   act_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [W-1:0]  tsig_q,  tsig_d;
  logic          wrap_q,  wrap_d;
  logic [W-1:0]  dec_s;
  mode_e         mode_s;

  assign mode_s = mode_e'(mode);

  onehot_dec #(.N(N)) u_dec (
    .idx    (cur_d),
    .onehot (dec_s)
  );

  // Next-state decode: clr, then enable, then command.
  always_comb begin
    cur_d   = cur_q;
    act_d   = act_q;
    presc_d = presc_q;
    wrap_d  = 1'b0;
    if (clr) begin
      cur_d   = IDX_ZERO;
      act_d   = 1'b0;
      presc_d = PRESC_ZERO;
    end else if (!en) begin
      presc_d = presc_q;
    end else begin
      case (mode_s)
        MODE_HOLD: begin
          presc_d = PRESC_ZERO;
        end
        MODE_LOAD: begin
          cur_d   = idx;
          act_d   = 1'b1;
          presc_d = PRESC_ZERO;
        end
        MODE_ROT_UP, MODE_ROT_DN: begin
          if (!act_q) begin
            presc_d = PRESC_ZERO;
          end else if (presc_q != PRESC_LAST) begin
            presc_d = presc_q + PW'(1);
          end else begin
            presc_d = PRESC_ZERO;
            // Index arithmetic wraps naturally modulo 2**N.
            if (mode_s == MODE_ROT_UP) begin
              cur_d  = cur_q + N'(1);
              wrap_d = (cur_q == IDX_MAX);
            end else begin
              cur_d  = cur_q - N'(1);
              wrap_d = (cur_q == IDX_ZERO);
            end
          end
        end
        default: begin
          presc_d = PRESC_ZERO;
        end
      endcase
    end
    if (act_d) begin
      tsig_d = dec_s;
    end else begin
      tsig_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q   <= IDX_ZERO;
      act_q   <= 1'b0;
      presc_q <= PRESC_ZERO;
      tsig_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      cur_q   <= cur_d;
      act_q   <= act_d;
      presc_q <= presc_d;
      tsig_q  <= tsig_d;
      wrap_q  <= wrap_d;
    end
  end

  assign Tsig    = tsig_q;
  assign cur_idx = cur_q;
  assign active  = act_q;
  assign wrap    = wrap_q;

  logic unused_s;
  assign unused_s = is_rotate(mode_s);

endmodule

// File: tb/tb_onehot_select_seq.sv
// Randomized + directed bench for onehot_select_seq with an index-level reference model.
module tb_onehot_select_seq;
  import onehot_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        en  = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [3:0]  idx  = 4'd0;

  logic [15:0] tsig0, tsig1;
  logic [3:0]  cur0, cur1;
  logic        act0, act1, wrap0, wrap1;

  int checks   = 0;
  int failures = 0;

  // Reference state per instance: 0 -> STEP_DIV=1, 1 -> STEP_DIV=3
  int m_cur[2];
  int m_presc[2];
  bit m_act[2];
  bit m_wrap[2];
  int sd[2] = '{1, 3};

  always #5 clk = ~clk;

  onehot_select_seq #(.N(4), .STEP_DIV(1)) u_sd1 (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .mode(mode), .idx(idx),
    .Tsig(tsig0), .cur_idx(cur0), .active(act0), .wrap(wrap0)
  );

  onehot_select_seq #(.N(4), .STEP_DIV(3)) u_sd3 (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .mode(mode), .idx(idx),
    .Tsig(tsig1), .cur_idx(cur1), .active(act1), .wrap(wrap1)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cur[k] = 0; m_presc[k] = 0; m_act[k] = 0; m_wrap[k] = 0;
    end
  endtask

  // Apply one clock edge of the rules to instance k using the current inputs.
  task automatic model_step(input int k);
    m_wrap[k] = 0;
    if (clr) begin
      m_cur[k] = 0; m_act[k] = 0; m_presc[k] = 0;
    end else if (en) begin
      if (mode == 2'b00) begin
        m_presc[k] = 0;
      end else if (mode == 2'b01) begin
        m_cur[k] = int'(idx); m_act[k] = 1; m_presc[k] = 0;
      end else if (!m_act[k]) begin
        m_presc[k] = 0;
      end else begin
        m_presc[k] = m_presc[k] + 1;
        if (m_presc[k] == sd[k]) begin
          m_presc[k] = 0;
          if (mode == 2'b10) begin
            m_wrap[k] = (m_cur[k] == 15);
            m_cur[k]  = (m_cur[k] + 1) % 16;
          end else begin
            m_wrap[k] = (m_cur[k] == 0);
            m_cur[k]  = (m_cur[k] + 15) % 16;
          end
        end
      end
    end
  endtask

  function automatic logic [15:0] exp_tsig(input int k);
    return m_act[k] ? 16'(32'd1 << m_cur[k]) : 16'd0;
  endfunction

  task automatic check_all();
    check("tsig_sd1",   {16'd0, tsig0}, {16'd0, exp_tsig(0)});
    check("cur_sd1",    {28'd0, cur0},  32'(m_cur[0]));
    check("active_sd1", {31'd0, act0},  {31'd0, m_act[0]});
    check("wrap_sd1",   {31'd0, wrap0}, {31'd0, m_wrap[0]});
    check("tsig_sd3",   {16'd0, tsig1}, {16'd0, exp_tsig(1)});
    check("cur_sd3",    {28'd0, cur1},  32'(m_cur[1]));
    check("active_sd3", {31'd0, act1},  {31'd0, m_act[1]});
    check("wrap_sd3",   {31'd0, wrap1}, {31'd0, m_wrap[1]});
  endtask

  task automatic tick(input logic c, input logic e, input logic [1:0] m, input logic [3:0] i);
    clr = c; en = e; mode = m; idx = i;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check("async_rst_tsig_sd1", {16'd0, tsig0}, 32'd0);
    check("async_rst_tsig_sd3", {16'd0, tsig1}, 32'd0);
    check("async_rst_act_sd1",  {31'd0, act0},  32'd0);
    check("async_rst_cur_sd3",  {28'd0, cur1},  32'd0);
    model_reset();
    #1 rst = 1'b0;
  endtask

  logic [3:0] seq_cur[6]  = '{4'd0, 4'd0, 4'd15, 4'd15, 4'd15, 4'd14};
  logic       seq_wrap[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    model_reset();
    #12;
    check("rst_tsig", {16'd0, tsig0}, 32'd0);
    check("rst_cur",  {28'd0, cur1},  32'd0);
    check_all();
    rst = 1'b0;

    // Load then immediate one-hot
    tick(1'b0, 1'b1, MODE_LOAD, 4'd5);
    check("load5_tsig", {16'd0, tsig0}, 32'h0020);
    check("load5_cur",  {28'd0, cur0},  32'd5);

    // Up-rotation across the wrap boundary
    tick(1'b0, 1'b1, MODE_LOAD, 4'd14);
    tick(1'b0, 1'b1, MODE_ROT_UP, 4'd0);
    check("up_15_tsig", {16'd0, tsig0}, 32'h8000);
    check("up_15_wrap", {31'd0, wrap0}, 32'd0);
    tick(1'b0, 1'b1, MODE_ROT_UP, 4'd0);
    check("up_0_tsig", {16'd0, tsig0}, 32'h0001);
    check("up_0_wrap", {31'd0, wrap0}, 32'd1);
    tick(1'b0, 1'b1, MODE_ROT_UP, 4'd0);
    check("up_1_tsig", {16'd0, tsig0}, 32'h0002);
    check("up_1_wrap", {31'd0, wrap0}, 32'd0);

    // Prescaled down-rotation through zero
    tick(1'b0, 1'b1, MODE_LOAD, 4'd0);
    for (int s = 0; s < 6; s++) begin
      tick(1'b0, 1'b1, MODE_ROT_DN, 4'd0);
      check($sformatf("dn_sd3_cur%0d", s),  {28'd0, cur1},  {28'd0, seq_cur[s]});
      check($sformatf("dn_sd3_wrap%0d", s), {31'd0, wrap1}, {31'd0, seq_wrap[s]});
    end

    // Rotation while inactive does nothing; clr mid-rotation
    tick(1'b1, 1'b1, MODE_LOAD, 4'd7);
    for (int s = 0; s < 4; s++) begin
      tick(1'b0, 1'b1, MODE_ROT_UP, 4'd9);
      check("inact_tsig", {16'd0, tsig0}, 32'd0);
      check("inact_wrap", {31'd0, wrap0}, 32'd0);
    end
    tick(1'b0, 1'b1, MODE_LOAD, 4'd3);
    tick(1'b0, 1'b1, MODE_ROT_UP, 4'd0);
    tick(1'b0, 1'b1, MODE_ROT_UP, 4'd0);
    tick(1'b1, 1'b1, MODE_ROT_UP, 4'd0);
    check("clr_tsig", {16'd0, tsig0}, 32'd0);
    check("clr_cur",  {28'd0, cur0},  32'd0);

    // en=0 freezes prescaler phase
    tick(1'b0, 1'b1, MODE_LOAD, 4'd2);
    tick(1'b0, 1'b1, MODE_ROT_UP, 4'd0);
    for (int s = 0; s < 5; s++) begin
      tick(1'b0, 1'b0, MODE_ROT_UP, 4'd0);
      check("frozen_cur_sd3", {28'd0, cur1}, 32'd2);
    end
    tick(1'b0, 1'b1, MODE_ROT_UP, 4'd0);
    check("resume_cur_sd3_a", {28'd0, cur1}, 32'd2);
    tick(1'b0, 1'b1, MODE_ROT_UP, 4'd0);
    check("resume_cur_sd3_b", {28'd0, cur1}, 32'd3);

    // Asynchronous reset while Tsig=0x0400
    tick(1'b0, 1'b1, MODE_LOAD, 4'd10);
    check("pre_async_tsig", {16'd0, tsig0}, 32'h0400);
    async_reset();
    tick(1'b0, 1'b1, MODE_ROT_UP, 4'd0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic       rc, re;
      logic [1:0] rm;
      logic [3:0] ri;
      rc = ($urandom_range(0, 24) == 0);
      re = ($urandom_range(0, 4) != 0);
      rm = ($urandom_range(0, 5) == 0) ? 2'b01 : 2'($urandom_range(0, 3));
      ri = 4'($urandom_range(0, 15));
      tick(rc, re, rm, ri);
      if ((n % 97) == 96) begin
        async_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/onehot_select_seq.md
ONEHOT_SELECT_SEQ -- requirements
Module: onehot_select_seq

Interface
REQ-001 Parameter N, default 4, index width; output width is 2**N; legal range 1..8.
REQ-002 Parameter STEP_DIV, default 1, rotate prescale; legal range 1..256.
REQ-003 Port clk  in  1  sole clock, rising edge.
REQ-004 Port rst  in  1  reset, asynchronous, active-high.
REQ-005 Port clr  in  1  synchronous clear, highest priority after rst.
REQ-006 Port en  in  1  command enable; 0 = hold all state.
REQ-007 Port mode  in  2  command: 00 HOLD, 01 LOAD, 10 ROT_UP, 11 ROT_DN.
REQ-008 Port idx  in  N  index captured on LOAD.
REQ-009 Port Tsig  out  2**N  registered one-hot select, all-zero when inactive.
REQ-010 Port cur_idx  out  N  current index register.
REQ-011 Port active  out  1  select valid flag.
REQ-012 Port wrap  out  1  one-cycle pulse on index wrap-around.

Function
REQ-013 State: cur (N bits), act (1 bit), presc (counter 0..STEP_DIV-1), Tsig register, wrap register.
REQ-014 Tsig next = act_next ? (1 << cur_next) : 0; Tsig, active and cur_idx update on the same edge; command-to-output latency is 1 clock.
REQ-015 Priority per edge: clr > en=0 > mode decode.
REQ-016 clr=1: act<=0, cur<=0, presc<=0, Tsig<=0, wrap<=0, regardless of en/mode.
REQ-017 en=0 (clr=0): cur, act, presc and Tsig hold; wrap<=0.
REQ-018 HOLD: cur, act and Tsig hold; presc<=0; wrap<=0.
REQ-019 LOAD: cur<=idx, act<=1, presc<=0, wrap<=0; LOAD while active overwrites cur without a zero gap in Tsig.
REQ-020 ROT_UP/ROT_DN with act=0: no state change; presc stays 0; wrap<=0.
REQ-021 ROT_* with act=1 and presc<STEP_DIV-1: presc<=presc+1; cur holds; wrap<=0.
REQ-022 ROT_* with act=1 and presc==STEP_DIV-1: presc<=0; cur advances by +1 (UP) or -1 (DN), modulo 2**N.
REQ-023 Wrap: UP from 2**N-1 to 0, or DN from 0 to 2**N-1, sets wrap<=1 for exactly that cycle; otherwise wrap<=0.
REQ-024 STEP_DIV=1: cur advances every enabled ROT_* cycle.
REQ-025 Switching between ROT_UP and ROT_DN does not clear presc; any non-rotate command or clr clears it.
REQ-026 Tsig has at most one bit set in every cycle; popcount(Tsig)==active at all times.

Reset
REQ-027 rst=1 asynchronously forces cur=0, act=0, presc=0, Tsig=0, wrap=0, active=0, cur_idx=0.
REQ-028 Reset asserted mid-rotation discards presc progress; first edge after deassertion obeys REQ-015 with no residual wrap pulse.

Structure
REQ-029 Mode encodings (HOLD, LOAD, ROT_UP, ROT_DN) and their 2-bit width live in the shared package onehot_pkg.
REQ-030 Index-to-one-hot conversion is a combinational sub-module onehot_dec parametrised by N, instantiated once on cur_next.
REQ-031 All state is held in a single always block on posedge clk or posedge rst.

Verification
REQ-032 N=4, STEP_DIV=1: rst, then LOAD idx=5 -> next cycle Tsig=16'h0020, active=1, cur_idx=5.
REQ-033 N=4, STEP_DIV=1: LOAD 14, then 3 cycles ROT_UP -> Tsig 16'h8000, 16'h0001 (wrap=1 that cycle only), 16'h0002.
REQ-034 N=4, STEP_DIV=3: LOAD 0, then ROT_DN for 6 cycles -> cur 0,0,15 (wrap=1),15,15,14.
REQ-035 ROT_UP with active=0 for 4 cycles -> Tsig=0, wrap=0 throughout; then clr during active rotation -> next cycle Tsig=0, cur_idx=0.
REQ-036 en=0 for 5 cycles while mode=ROT_UP and STEP_DIV=3 -> cur and presc frozen; rotation resumes at the same prescale phase when en returns to 1.
REQ-037 rst asserted asynchronously between edges while Tsig=16'h0400 -> Tsig=0 immediately, before the next clock edge.
